spi_slave: RTL

//  SPI responder (slave) for the RAMP SoC peripheral fabric; the far end of our SPI master links.

---
 rtl/spi_slave_if.sv | 40 ++++
 rtl/spi_slave.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// Bus bundle for spi_slave: firmware-side TX/RX words plus the SPI pad signals.
// The o_TX_Underrun flag is present only when SPI_SLAVE_UNDERRUN_EN is defined.
interface spi_slave_if;
    logic [1:0]  i_spi_mode;
    logic [3:0]  i_data_length;
    logic [15:0] i_TX_Data;
    logic        i_TX_DV;
    logic        o_TX_Ready;
    logic        o_RX_DV;
    logic [15:0] o_RX_Data;
    logic        i_SPI_Clk;
    logic        i_SPI_CS_n;
    logic        i_SPI_MOSI;
    logic        o_SPI_MISO;
    logic        o_SPI_MISO_En;
    logic        o_dbg_state;
`ifdef SPI_SLAVE_UNDERRUN_EN
    logic        o_TX_Underrun;
`endif

    // TX handshake: i_TX_DV is a one-cycle write strobe; the word is taken only when
    // o_TX_Ready=1 in that same cycle. RX: o_RX_DV pulses for one cycle with o_RX_Data valid.
    modport slave (
        input  i_spi_mode, i_data_length, i_TX_Data, i_TX_DV,
        input  i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI,
`ifdef SPI_SLAVE_UNDERRUN_EN
        output o_TX_Underrun,
`endif
        output o_TX_Ready, o_RX_DV, o_RX_Data, o_SPI_MISO, o_SPI_MISO_En, o_dbg_state
    );

    modport master (
        output i_spi_mode, i_data_length, i_TX_Data, i_TX_DV,
        output i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI,
`ifdef SPI_SLAVE_UNDERRUN_EN
        input  o_TX_Underrun,
`endif
        input  o_TX_Ready, o_RX_DV, o_RX_Data, o_SPI_MISO, o_SPI_MISO_En, o_dbg_state
    );
endinterface

// File: rtl/spi_slave.sv
// Oversampling SPI responder, modes 0-3, 4..16-bit words, single-entry TX buffer.
// Define SPI_SLAVE_UNDERRUN_EN to add the sticky o_TX_Underrun flag.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    spi_slave_if.slave  bus
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    logic        w_sclk;
    logic        w_cs;
    logic        w_mosi;
    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_lead;
    logic        w_trail;
    logic        w_sample;
    logic        w_shift;
    logic        w_cs_fall;
    logic        w_cs_rise;
    logic        w_start;
    logic        w_stop;
    logic        w_word_done;
    logic        w_consume;
    logic        w_tx_accept;
    logic [15:0] w_tx_load;
    logic [15:0] w_rx_word;

    logic [1:0]  r_mode;
    logic [3:0]  r_len;
    logic [3:0]  r_rx_cnt;
    logic [3:0]  r_tx_cnt;
    logic [15:0] r_rx_shift;
    logic [15:0] r_tx_shift;
    logic [15:0] r_tx_buf;
    logic        r_tx_full;
    logic        r_rx_dv;
    logic [15:0] r_rx_data;
    logic        r_miso;
    logic        r_hold;

    // Newest sample enters bit 0; the oldest (fully synchronised) sample is the MSB.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.i_SPI_Clk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.i_SPI_CS_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.i_SPI_MOSI};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs;
        end
    end

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_fall   = r_cs_d & ~w_cs;
    assign w_cs_rise   = ~r_cs_d & w_cs;

    // Leading edge leaves the CPOL idle level; CPHA picks which edge samples.
    assign w_lead   = r_mode[1] ? w_sclk_fall : w_sclk_rise;
    assign w_trail  = r_mode[1] ? w_sclk_rise : w_sclk_fall;
    assign w_sample = (r_state == ST_ACTIVE) & (r_mode[0] ? w_trail : w_lead);
    assign w_shift  = (r_state == ST_ACTIVE) & (r_mode[0] ? w_lead : w_trail);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_stop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = ST_ACTIVE;
                    w_start      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_next = ST_IDLE;
                    w_stop       = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_word_done = w_sample & (r_rx_cnt == 4'd0) & ~w_stop;
    assign w_consume   = w_start | w_word_done;
    assign w_tx_accept = bus.i_TX_DV & ~r_tx_full;
    assign w_tx_load   = r_tx_full ? r_tx_buf : 16'h0000;
    assign w_rx_word   = {r_rx_shift[15:1], w_mosi};

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_tx_buf  <= 16'h0000;
            r_tx_full <= 1'b0;
        end else if (w_tx_accept) begin
            r_tx_buf  <= bus.i_TX_Data;
            r_tx_full <= 1'b1;
        end else if (w_consume) begin
            r_tx_full <= 1'b0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_mode     <= 2'd0;
            r_len      <= 4'd15;
            r_rx_cnt   <= 4'd15;
            r_tx_cnt   <= 4'd15;
            r_rx_shift <= 16'h0000;
            r_tx_shift <= 16'h0000;
            r_rx_dv    <= 1'b0;
            r_rx_data  <= 16'h0000;
            r_miso     <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            r_rx_dv <= 1'b0;
            if (w_start) begin
                r_mode     <= bus.i_spi_mode;
                r_len      <= bus.i_data_length;
                r_rx_cnt   <= bus.i_data_length;
                r_tx_cnt   <= bus.i_data_length;
                r_tx_shift <= w_tx_load;
                r_rx_shift <= 16'h0000;
                r_hold     <= 1'b0;
                r_miso     <= bus.i_spi_mode[0] ? 1'b0 : w_tx_load[bus.i_data_length];
            end else if (w_stop) begin
                r_miso <= 1'b0;
                r_hold <= 1'b0;
            end else if (w_sample) begin
                if (r_rx_cnt == 4'd0) begin
                    r_rx_dv    <= 1'b1;
                    r_rx_data  <= w_rx_word;
                    r_rx_cnt   <= r_len;
                    r_tx_cnt   <= r_len;
                    r_tx_shift <= w_tx_load;
                    r_rx_shift <= 16'h0000;
                    // CPHA=0: next MSB goes out now; the trailing edge that closes
                    // the finished word must then leave it in place.
                    if (!r_mode[0]) begin
                        r_miso <= w_tx_load[r_len];
                        r_hold <= 1'b1;
                    end
                end else begin
                    r_rx_shift[r_rx_cnt] <= w_mosi;
                    r_rx_cnt             <= r_rx_cnt - 4'd1;
                end
            end else if (w_shift) begin
                if (r_mode[0]) begin
                    r_miso   <= r_tx_shift[r_tx_cnt];
                    r_tx_cnt <= r_tx_cnt - 4'd1;
                end else if (r_hold) begin
                    r_hold <= 1'b0;
                end else if (r_tx_cnt != 4'd0) begin
                    r_miso   <= r_tx_shift[r_tx_cnt - 4'd1];
                    r_tx_cnt <= r_tx_cnt - 4'd1;
                end
            end
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    logic r_underrun;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_underrun <= 1'b0;
        end else if (w_consume && !r_tx_full) begin
            r_underrun <= 1'b1;
        end else if (w_tx_accept) begin
            r_underrun <= 1'b0;
        end
    end

    assign bus.o_TX_Underrun = r_underrun;
`endif

    assign bus.o_TX_Ready    = ~r_tx_full;
    assign bus.o_RX_DV       = r_rx_dv;
    assign bus.o_RX_Data     = r_rx_data;
    assign bus.o_SPI_MISO    = r_miso;
    assign bus.o_SPI_MISO_En = (r_state == ST_ACTIVE);
    assign bus.o_dbg_state   = r_state;

endmodule
